// File: rtl/thunderbird_lamp_decoder.sv
// Thunderbird tail-light bus observer.
// Samples the lamp patterns each clock and rebuilds the turn request. It checks
// every transition against the legal left, right and hazard sequences, and it
// counts completed sequences and illegal transitions. Both counts saturate.
// Ports:
//   clock      rising-edge system clock
//   reset      synchronous, active-high reset
//   L, R       lamp patterns, bit0 inner .. bit2 outer
//   mode       decoded request: 00 idle, 01 left, 10 right, 11 hazard
//   seq_done   one-cycle pulse when a sequence completes
//   err        one-cycle pulse on an illegal transition
//   seq_count  completed sequences (saturating)
//   err_count  illegal transitions (saturating)
module thunderbird_lamp_decoder #(
    parameter int unsigned CW        = 8,
    parameter int unsigned IDLE_HOLD = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    L,
    input  logic [2:0]    R,
    output logic [1:0]    mode,
    output logic          seq_done,
    output logic          err,
    output logic [CW-1:0] seq_count,
    output logic [CW-1:0] err_count
);

    localparam int unsigned ICW = 4;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_HAZ   = 2'b11;

    // Samples are {L, R}
    localparam logic [5:0] P_OFF = 6'b000_000;
    localparam logic [5:0] P_L1  = 6'b001_000;
    localparam logic [5:0] P_L2  = 6'b011_000;
    localparam logic [5:0] P_L3  = 6'b111_000;
    localparam logic [5:0] P_R1  = 6'b000_001;
    localparam logic [5:0] P_R2  = 6'b000_011;
    localparam logic [5:0] P_R3  = 6'b000_111;
    localparam logic [5:0] P_HAZ = 6'b111_111;

    localparam logic [ICW-1:0] HOLD = ICW'(IDLE_HOLD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_L3,
        S_R1,
        S_R2,
        S_R3,
        S_HAZ,
        S_RESYNC
    } state_t;

    state_t         state_q, state_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           seq_done_q, err_q;
    logic [CW-1:0]  seq_count_q, seq_count_d;
    logic [CW-1:0]  err_count_q, err_count_d;
    logic           done_c, bad_c;
    logic [5:0]     sample;

    assign sample = {L, R};

    // Next-state and sequence checking
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        mode_d     = mode_q;
        done_c     = 1'b0;
        bad_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sample == P_OFF) begin
                    if (idle_cnt_q < HOLD) idle_cnt_d = idle_cnt_q + ICW'(1);
                end else if (sample == P_L1) begin
                    state_d = S_L1;
                    mode_d  = MODE_LEFT;
                end else if (sample == P_R1) begin
                    state_d = S_R1;
                    mode_d  = MODE_RIGHT;
                end else if (sample == P_HAZ) begin
                    state_d = S_HAZ;
                    mode_d  = MODE_HAZ;
                end else begin
                    bad_c = 1'b1;
                end
            end
            S_L1: if (sample == P_L2) state_d = S_L2; else bad_c = 1'b1;
            S_L2: if (sample == P_L3) state_d = S_L3; else bad_c = 1'b1;
            S_R1: if (sample == P_R2) state_d = S_R2; else bad_c = 1'b1;
            S_R2: if (sample == P_R3) state_d = S_R3; else bad_c = 1'b1;
            S_L3, S_R3, S_HAZ: begin
                if (sample == P_OFF) begin
                    state_d    = S_IDLE;
                    idle_cnt_d = ICW'(1);
                    done_c     = 1'b1;
                end else begin
                    bad_c = 1'b1;
                end
            end
            S_RESYNC: begin
                // Wait quietly for the lamps to go dark before re-arming
                if (sample == P_OFF) begin
                    state_d    = S_IDLE;
                    idle_cnt_d = ICW'(1);
                end
            end
            default: state_d = S_RESYNC;
        endcase

        if (bad_c) begin
            state_d = S_RESYNC;
            mode_d  = MODE_IDLE;
        end

        // Mode survives short idle gaps so back-to-back flashing stays steady
        if (state_d != S_IDLE) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_d >= HOLD) begin
            mode_d = MODE_IDLE;
        end
    end

    // Saturating event counters
    always_comb begin
        seq_count_d = seq_count_q;
        err_count_d = err_count_q;
        if (done_c && (seq_count_q != '1)) seq_count_d = seq_count_q + CW'(1);
        if (bad_c && (err_count_q != '1)) err_count_d = err_count_q + CW'(1);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idle_cnt_q  <= '0;
            mode_q      <= MODE_IDLE;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
            seq_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            mode_q      <= mode_d;
            seq_done_q  <= done_c;
            err_q       <= bad_c;
            seq_count_q <= seq_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign mode      = mode_q;
    assign seq_done  = seq_done_q;
    assign err       = err_q;
    assign seq_count = seq_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_thunderbird_lamp_decoder.sv
// Directed bench for thunderbird_lamp_decoder: a vector table plus hand-written
// reset-mid-sequence and counter-saturation sequences. A second instance with
// CW = 2 shares the stimulus for the saturation checks.
module tb_thunderbird_lamp_decoder;

    logic       clock;
    logic       reset;
    logic [2:0] L;
    logic [2:0] R;

    logic [1:0] mode, mode_s;
    logic       seq_done, seq_done_s;
    logic       err, err_s;
    logic [7:0] seq_count, err_count;
    logic [1:0] seq_count_s, err_count_s;

    int total = 0;
    int bad   = 0;

    thunderbird_lamp_decoder #(.CW(8), .IDLE_HOLD(2)) dut (
        .clock(clock), .reset(reset), .L(L), .R(R),
        .mode(mode), .seq_done(seq_done), .err(err),
        .seq_count(seq_count), .err_count(err_count)
    );

    thunderbird_lamp_decoder #(.CW(2), .IDLE_HOLD(2)) dut_sat (
        .clock(clock), .reset(reset), .L(L), .R(R),
        .mode(mode_s), .seq_done(seq_done_s), .err(err_s),
        .seq_count(seq_count_s), .err_count(err_count_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [2:0] l;
        logic [2:0] r;
        logic [1:0] mode;
        logic       done;
        logic       err;
        int         sc;
        int         ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] l, input logic [2:0] r,
                       input logic [1:0] m, input logic d, input logic e,
                       input int sc, input int ec);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.mode = m; v.done = d; v.err = e;
        v.sc = sc; v.ec = ec;
        vecs.push_back(v);
    endtask

    // Drive one sample, then look at the outputs just after the edge that took it
    task automatic apply(input logic rst, input logic [2:0] l, input logic [2:0] r);
        @(negedge clock);
        reset = rst;
        L     = l;
        R     = r;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int d, input int e,
                             input int sc, input int ec);
        check({tag, ".mode"}, int'(mode), m);
        check({tag, ".seq_done"}, int'(seq_done), d);
        check({tag, ".err"}, int'(err), e);
        check({tag, ".seq_count"}, int'(seq_count), sc);
        check({tag, ".err_count"}, int'(err_count), ec);
    endtask

    int done_pulses;
    int err_pulses;

    initial begin
        reset = 1'b1;
        L     = 3'b000;
        R     = 3'b000;

        // Left sequence twice, then mode clears after the idle hold
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 0, 0);
        add(0, 3'b001, 3'b000, 2'd1, 0, 0, 0, 0);
        add(0, 3'b011, 3'b000, 2'd1, 0, 0, 0, 0);
        add(0, 3'b111, 3'b000, 2'd1, 0, 0, 0, 0);
        add(0, 3'b000, 3'b000, 2'd1, 1, 0, 1, 0);
        add(0, 3'b001, 3'b000, 2'd1, 0, 0, 1, 0);
        add(0, 3'b011, 3'b000, 2'd1, 0, 0, 1, 0);
        add(0, 3'b111, 3'b000, 2'd1, 0, 0, 1, 0);
        add(0, 3'b000, 3'b000, 2'd1, 1, 0, 2, 0);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 2, 0);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 2, 0);
        // Right sequence then hazard
        add(0, 3'b000, 3'b001, 2'd2, 0, 0, 2, 0);
        add(0, 3'b000, 3'b011, 2'd2, 0, 0, 2, 0);
        add(0, 3'b000, 3'b111, 2'd2, 0, 0, 2, 0);
        add(0, 3'b000, 3'b000, 2'd2, 1, 0, 3, 0);
        add(0, 3'b111, 3'b111, 2'd3, 0, 0, 3, 0);
        add(0, 3'b000, 3'b000, 2'd3, 1, 0, 4, 0);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 4, 0);
        // Illegal skip, silent resync, then a clean left sequence
        add(0, 3'b001, 3'b000, 2'd1, 0, 0, 4, 0);
        add(0, 3'b111, 3'b000, 2'd0, 0, 1, 4, 1);
        add(0, 3'b111, 3'b000, 2'd0, 0, 0, 4, 1);
        add(0, 3'b011, 3'b000, 2'd0, 0, 0, 4, 1);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 4, 1);
        add(0, 3'b001, 3'b000, 2'd1, 0, 0, 4, 1);
        add(0, 3'b011, 3'b000, 2'd1, 0, 0, 4, 1);
        add(0, 3'b111, 3'b000, 2'd1, 0, 0, 4, 1);
        add(0, 3'b000, 3'b000, 2'd1, 1, 0, 5, 1);
        // Reset with junk on the bus, then mixed lamps from idle
        add(1, 3'b001, 3'b000, 2'd0, 0, 0, 0, 0);
        add(0, 3'b001, 3'b001, 2'd0, 0, 1, 0, 1);
        add(0, 3'b001, 3'b001, 2'd0, 0, 0, 0, 1);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 0, 1);
        // Right then left with no full idle gap: mode switches directly
        add(0, 3'b000, 3'b001, 2'd2, 0, 0, 0, 1);
        add(0, 3'b000, 3'b011, 2'd2, 0, 0, 0, 1);
        add(0, 3'b000, 3'b111, 2'd2, 0, 0, 0, 1);
        add(0, 3'b000, 3'b000, 2'd2, 1, 0, 1, 1);
        add(0, 3'b001, 3'b000, 2'd1, 0, 0, 1, 1);
        add(0, 3'b011, 3'b000, 2'd1, 0, 0, 1, 1);
        add(0, 3'b111, 3'b000, 2'd1, 0, 0, 1, 1);
        add(0, 3'b000, 3'b000, 2'd1, 1, 0, 2, 1);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 2, 1);
        // Hazard held on is illegal
        add(0, 3'b111, 3'b111, 2'd3, 0, 0, 2, 1);
        add(0, 3'b111, 3'b111, 2'd0, 0, 1, 2, 2);
        add(0, 3'b000, 3'b000, 2'd0, 0, 0, 2, 2);

        // Reset state
        apply(1, 3'b000, 3'b000);
        check_all("reset", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].l, vecs[i].r);
            check_all($sformatf("vec%0d", i), int'(vecs[i].mode), int'(vecs[i].done),
                      int'(vecs[i].err), vecs[i].sc, vecs[i].ec);
        end

        // Reset while in S_L2 abandons the sequence
        apply(1, 3'b000, 3'b000);
        apply(0, 3'b001, 3'b000);
        apply(0, 3'b011, 3'b000);
        apply(0, 3'b111, 3'b000);
        apply(0, 3'b000, 3'b000);
        apply(0, 3'b001, 3'b000);
        apply(0, 3'b011, 3'b000);
        check_all("pre_reset", 1, 0, 0, 1, 0);
        apply(1, 3'b111, 3'b000);
        check_all("mid_reset", 0, 0, 0, 0, 0);
        apply(0, 3'b011, 3'b000);
        check_all("after_reset", 0, 0, 1, 0, 1);

        // Saturation: five sequences and four errors on the CW=2 instance
        apply(1, 3'b000, 3'b000);
        done_pulses = 0;
        for (int n = 0; n < 5; n++) begin
            apply(0, 3'b001, 3'b000);
            if (seq_done_s) done_pulses++;
            apply(0, 3'b011, 3'b000);
            if (seq_done_s) done_pulses++;
            apply(0, 3'b111, 3'b000);
            if (seq_done_s) done_pulses++;
            apply(0, 3'b000, 3'b000);
            if (seq_done_s) done_pulses++;
        end
        check("sat.seq_count", int'(seq_count_s), 3);
        check("sat.done_pulses", done_pulses, 5);
        check("wide.seq_count", int'(seq_count), 5);
        err_pulses = 0;
        for (int n = 0; n < 4; n++) begin
            apply(0, 3'b001, 3'b001);
            if (err_s) err_pulses++;
            apply(0, 3'b000, 3'b000);
            if (err_s) err_pulses++;
        end
        check("sat.err_count", int'(err_count_s), 3);
        check("sat.err_pulses", err_pulses, 4);
        check("wide.err_count", int'(err_count), 4);
        check("sat.seq_count_hold", int'(seq_count_s), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
